// File: rtl/dna_access_ctrl.sv
// dna_access_ctrl: DNA_PORT start-up sequencer, 57-bit DNA cache
// and round-robin server for internal requesters.
module dna_access_ctrl #(
    parameter int NUM_REQ   = 4,
    parameter int START_DLY = 20
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               dna_rdy,
    input  logic               dna_dout,
    output logic               dna_read,
    output logic               dna_shift,
    input  logic               reread,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               rsp_valid,
    output logic [2:0]         rsp_id,
    output logic [56:0]        rsp_data,
    output logic [56:0]        dna_data,
    output logic               dna_valid,
    output logic               busy
);

    localparam int WCW = (START_DLY > 1) ? $clog2(START_DLY) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_LOAD,
        S_GAP,
        S_SHIFT,
        S_SERVE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WCW-1:0]     r_wcnt;
    logic [5:0]         r_bcnt;
    logic [56:0]        r_dna;
    logic               r_valid;
    logic               r_read;
    logic               r_shift;
    logic               r_busy;
    logic [2:0]         r_ptr;
    logic [NUM_REQ-1:0] r_gnt;
    logic               r_rsp_vld;
    logic [2:0]         r_rsp_id;
    logic [56:0]        r_rsp_data;

    logic               w_hit;
    logic [2:0]         w_idx;
    logic [3:0]         w_sum;
    logic [2:0]         w_ptr_nxt;
    logic               w_grant;
    logic               w_next_busy;

    // Next-state decode for the start-up / reread sequencer
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (dna_rdy) w_next = S_WAIT;
            S_WAIT:  if (dna_rdy && r_wcnt == WCW'(START_DLY - 1))
                         w_next = S_LOAD;
            S_LOAD:  w_next = S_GAP;
            S_GAP:   w_next = S_SHIFT;
            S_SHIFT: if (r_bcnt == 6'd56) w_next = S_SERVE;
            S_SERVE: if (reread) w_next = S_LOAD;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_next_busy = (w_next == S_WAIT) || (w_next == S_LOAD) ||
                         (w_next == S_GAP)  || (w_next == S_SHIFT);

    // State, counters, DNA capture and primitive pin registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
            r_wcnt  <= '0;
            r_bcnt  <= '0;
            r_dna   <= '0;
            r_valid <= 1'b0;
            r_read  <= 1'b0;
            r_shift <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE)
                r_wcnt <= '0;
            else if (r_state == S_WAIT && dna_rdy)
                r_wcnt <= r_wcnt + 1'b1;
            if (r_state == S_GAP)
                r_bcnt <= '0;
            else if (r_state == S_SHIFT)
                r_bcnt <= r_bcnt + 6'd1;
            if (r_state == S_SHIFT)
                r_dna <= {r_dna[55:0], dna_dout};
            if (w_next == S_LOAD)
                r_valid <= 1'b0;
            else if (r_state == S_SHIFT && w_next == S_SERVE)
                r_valid <= 1'b1;
            r_read  <= (w_next == S_LOAD);
            r_shift <= (w_next == S_SHIFT);
            r_busy  <= w_next_busy;
        end
    end

    // Round-robin search starting at the slot after the last grant
    always_comb begin
        w_hit = 1'b0;
        w_idx = 3'd0;
        w_sum = 4'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + 4'(k);
            if (w_sum >= 4'(NUM_REQ))
                w_sum = w_sum - 4'(NUM_REQ);
            if (!w_hit && |(req & (NUM_REQ'(1) << w_sum))) begin
                w_hit = 1'b1;
                w_idx = w_sum[2:0];
            end
        end
    end

    assign w_ptr_nxt = (w_idx == 3'(NUM_REQ - 1)) ? 3'd0 : w_idx + 3'd1;
    assign w_grant   = (r_state == S_SERVE) && w_hit;

    // Grant and response registers, all updated on the same edge
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_ptr      <= '0;
            r_gnt      <= '0;
            r_rsp_vld  <= 1'b0;
            r_rsp_id   <= '0;
            r_rsp_data <= '0;
        end else begin
            r_rsp_vld <= w_grant;
            if (w_grant) begin
                r_gnt      <= NUM_REQ'(1) << w_idx;
                r_rsp_id   <= w_idx;
                r_rsp_data <= r_dna;
                r_ptr      <= w_ptr_nxt;
            end else begin
                r_gnt <= '0;
            end
        end
    end

    assign dna_read  = r_read;
    assign dna_shift = r_shift;
    assign busy      = r_busy;
    assign dna_valid = r_valid;
    assign dna_data  = r_dna;
    assign gnt       = r_gnt;
    assign rsp_valid = r_rsp_vld;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;

endmodule
